// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO master: FSM states, frame field
// encodings and the header word builder.
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_DONE
  } mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int MDIO_HDR_BITS  = 14;
  localparam int MDIO_DATA_BITS = 16;

  // Header left-aligned in 16 bits so the first serial bit is always bit 15.
  function automatic logic [15:0] mdio_hdr(input logic       wr,
                                           input logic [4:0] phyad,
                                           input logic [4:0] regad);
    return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad, 2'b00};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: low for CLK_DIV cycles, then high for CLK_DIV cycles, while
// enabled. Ticks mark the last cycle before MDC changes level.
module mdio_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign rise_tick = enable && (cnt == LAST) && !mdc;
  assign fall_tick = enable && (cnt == LAST) && mdc;

  // Disabling clears the phase so every frame starts on a fresh low half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serializes one register read or write per command
// onto MDC/MDIO and returns a single-cycle response.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [4:0]  CMD_PHYAD,
  input  logic [4:0]  CMD_REGAD,
  input  logic [15:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  input  logic        MDIO_I
);

  mdio_state_t state;
  logic [5:0]  bit_cnt;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic        wr_q;
  logic [4:0]  phyad_q;
  logic [4:0]  regad_q;
  logic [15:0] wdata_q;
  logic        ta_err;
  logic        fall_tick;
  logic        rise_tick;
  logic [15:0] hdr_word;

  assign BUSY      = state inside {ST_PRE, ST_HDR, ST_TA, ST_DATA};
  assign CMD_READY = (state == ST_IDLE);
  assign RSP_VALID = (state == ST_DONE);
  assign hdr_word  = mdio_hdr(wr_q, phyad_q, regad_q);

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (CLK),
    .rst       (RESET),
    .enable    (BUSY),
    .mdc       (MDC),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  // Each state loads its first bit on entry; later bits shift out of tx_sr[15]
  // on every MDC falling edge, so MDIO changes together with MDC falling.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      wr_q      <= 1'b0;
      phyad_q   <= '0;
      regad_q   <= '0;
      wdata_q   <= '0;
      ta_err    <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      MDIO_O    <= 1'b1;
      MDIO_OE   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CMD_VALID) begin
            wr_q    <= CMD_WRITE;
            phyad_q <= CMD_PHYAD;
            regad_q <= CMD_REGAD;
            wdata_q <= CMD_WDATA;
            ta_err  <= 1'b0;
            bit_cnt <= 6'(PRE_LEN - 1);
            MDIO_O  <= 1'b1;
            MDIO_OE <= 1'b1;
            state   <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (fall_tick) begin
            if (bit_cnt == 6'd0) begin
              state   <= ST_HDR;
              bit_cnt <= 6'(MDIO_HDR_BITS - 1);
              tx_sr   <= hdr_word;
              MDIO_O  <= hdr_word[15];
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end
        ST_HDR: begin
          if (fall_tick) begin
            if (bit_cnt == 6'd0) begin
              state   <= ST_TA;
              bit_cnt <= 6'd1;
              if (wr_q) begin
                tx_sr  <= {MDIO_TA_WR, 14'd0};
                MDIO_O <= MDIO_TA_WR[1];
              end else begin
                MDIO_OE <= 1'b0;
                MDIO_O  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              tx_sr   <= {tx_sr[14:0], 1'b0};
              MDIO_O  <= tx_sr[14];
            end
          end
        end
        ST_TA: begin
          if (rise_tick && !wr_q && bit_cnt == 6'd0)
            ta_err <= MDIO_I;
          if (fall_tick) begin
            if (bit_cnt == 6'd0) begin
              state   <= ST_DATA;
              bit_cnt <= 6'(MDIO_DATA_BITS - 1);
              if (wr_q) begin
                tx_sr  <= wdata_q;
                MDIO_O <= wdata_q[15];
              end
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              tx_sr   <= {tx_sr[14:0], 1'b0};
              if (wr_q)
                MDIO_O <= tx_sr[14];
            end
          end
        end
        ST_DATA: begin
          if (rise_tick && !wr_q)
            rx_sr <= {rx_sr[14:0], MDIO_I};
          if (fall_tick) begin
            if (bit_cnt == 6'd0) begin
              state     <= ST_DONE;
              MDIO_OE   <= 1'b0;
              MDIO_O    <= 1'b1;
              RSP_RDATA <= wr_q ? 16'h0000 : rx_sr;
              RSP_ERR   <= !wr_q && ta_err;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              tx_sr   <= {tx_sr[14:0], 1'b0};
              if (wr_q)
                MDIO_O <= tx_sr[14];
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: a CLK_DIV=2 instance for frame content and
// handshake checks, plus a default-parameter instance for MDC timing.
module tb_mdio_master;

  localparam int FAST_DIV = 2;
  localparam int BITP     = 2 * FAST_DIV;

  logic CLK = 1'b0;
  logic RESET;

  logic        cmd_valid, cmd_write, cmd_ready;
  logic [4:0]  cmd_phyad, cmd_regad;
  logic [15:0] cmd_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe, mdio_i;

  logic        d_valid, d_write, d_ready;
  logic [4:0]  d_phyad, d_regad;
  logic [15:0] d_wdata, d_rdata;
  logic        d_rsp_valid, d_err, d_busy, d_mdc, d_mdio_o, d_oe;
  logic        d_mdio_i = 1'b1;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mdio_master #(.CLK_DIV(FAST_DIV), .PRE_LEN(32)) u_fast (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_PHYAD(cmd_phyad), .CMD_REGAD(cmd_regad), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .BUSY(busy), .MDC(mdc), .MDIO_O(mdio_o), .MDIO_OE(mdio_oe), .MDIO_I(mdio_i)
  );

  mdio_master u_dflt (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(d_valid), .CMD_READY(d_ready), .CMD_WRITE(d_write),
    .CMD_PHYAD(d_phyad), .CMD_REGAD(d_regad), .CMD_WDATA(d_wdata),
    .RSP_VALID(d_rsp_valid), .RSP_RDATA(d_rdata), .RSP_ERR(d_err),
    .BUSY(d_busy), .MDC(d_mdc), .MDIO_O(d_mdio_o), .MDIO_OE(d_oe), .MDIO_I(d_mdio_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                               input logic [15:0] wd);
    cmd_write = wr;
    cmd_phyad = pa;
    cmd_regad = ra;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
  endtask

  // Runs one fast-instance frame from handshake to the response cycle; the PHY
  // model drives TA=0 and rd when phy is set, otherwise the line floats high.
  task automatic runFrame(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input bit phy, input logic [15:0] rd,
                          input bit keep, input string tag, output int acc, output int rsp);
    logic [63:0] exp_bits, got;
    logic        prev_mdc, exp_oe;
    int          rises, oe_bad, ctl_bad, k;
    rises = 0; oe_bad = 0; ctl_bad = 0; got = '0; rsp = -1;
    exp_bits = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra,
                (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0000)};
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready && cmd_valid) break;
      @(negedge CLK);
    end
    checkOutput({tag, "_accept"}, 32'(cmd_ready && cmd_valid), 1);
    acc = cyc;
    checkOutput({tag, "_mdc_at_accept"}, 32'(mdc), 0);
    prev_mdc = mdc;
    for (int n = 1; n <= 300; n++) begin
      @(negedge CLK);
      if (!keep) cmd_valid = 1'b0;
      k = (n - 1) / BITP;
      if (!wr && phy)
        mdio_i = (k == 47) ? 1'b0 : ((k >= 48 && k <= 63) ? rd[63-k] : 1'b1);
      else
        mdio_i = 1'b1;
      if (rsp_valid) begin
        rsp = cyc;
        break;
      end
      if (!prev_mdc && mdc) begin
        if (rises < 64) got[63-rises] = mdio_o;
        rises++;
      end
      prev_mdc = mdc;
      if (cmd_ready || !busy) ctl_bad++;
      exp_oe = wr ? 1'b1 : (k < 46);
      if (mdio_oe !== exp_oe) oe_bad++;
    end
    checkOutput({tag, "_rsp_latency"}, 32'(rsp - acc), 257);
    checkOutput({tag, "_mdc_rises"}, 32'(rises), 64);
    checkOutput({tag, "_oe_errs"}, 32'(oe_bad), 0);
    checkOutput({tag, "_ready_busy_errs"}, 32'(ctl_bad), 0);
    checkOutput({tag, "_stream_hi"}, got[63:32], exp_bits[63:32]);
    checkOutput({tag, "_stream_lo"}, wr ? got[31:0] : {got[31:18], 18'h0},
                wr ? exp_bits[31:0] : {exp_bits[31:18], 18'h0});
    checkOutput({tag, "_rdata"}, 32'(rsp_rdata), wr ? 32'h0 : (phy ? 32'(rd) : 32'hFFFF));
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(!wr && !phy));
    checkOutput({tag, "_busy_done"}, 32'(busy), 0);
    checkOutput({tag, "_ready_done"}, 32'(cmd_ready), 0);
    checkOutput({tag, "_mdc_done"}, 32'(mdc), 0);
    checkOutput({tag, "_oe_done"}, 32'(mdio_oe), 0);
  endtask

  task automatic stepIdle(input string tag);
    @(negedge CLK);
    checkOutput({tag, "_ready_after"}, 32'(cmd_ready), 1);
    checkOutput({tag, "_rsp_pulse"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    int a, r, a2, r2, rsp_seen;
    int d_acc, d_rsp, d_rises, per_bad, hi_bad, chg_bad, last_rise;
    logic p_mdc, p_o, p_oe, rise, fall;

    RESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phyad = '0; cmd_regad = '0; cmd_wdata = '0;
    mdio_i = 1'b1;
    d_valid = 1'b0; d_write = 1'b0; d_phyad = '0; d_regad = '0; d_wdata = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_ready", 32'(cmd_ready), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_rdata", 32'(rsp_rdata), 0);
    checkOutput("reset_err", 32'(rsp_err), 0);
    checkOutput("reset_mdc", 32'(mdc), 0);
    checkOutput("reset_mdio_o", 32'(mdio_o), 1);
    checkOutput("reset_oe", 32'(mdio_oe), 0);
    RESET = 1'b0;
    @(negedge CLK);

    applyStimulus(1'b1, 5'd1, 5'd0, 16'h1140);
    runFrame(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 1'b0, "wr", a, r);
    stepIdle("wr");

    applyStimulus(1'b0, 5'd1, 5'd2, 16'h0000);
    runFrame(1'b0, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h796D, 1'b0, "rd", a, r);
    stepIdle("rd");

    applyStimulus(1'b1, 5'd3, 5'd4, 16'hA5C3);
    runFrame(1'b1, 5'd3, 5'd4, 16'hA5C3, 1'b0, 16'h0, 1'b1, "b2b_wr", a, r);
    applyStimulus(1'b0, 5'd3, 5'd2, 16'h0000);
    runFrame(1'b0, 5'd3, 5'd2, 16'h0000, 1'b1, 16'h796D, 1'b0, "b2b_rd", a2, r2);
    checkOutput("b2b_gap", 32'(a2 - r), 1);
    stepIdle("b2b");

    applyStimulus(1'b0, 5'd7, 5'd1, 16'h0000);
    runFrame(1'b0, 5'd7, 5'd1, 16'h0000, 1'b0, 16'h0, 1'b0, "nophy", a, r);
    stepIdle("nophy");

    applyStimulus(1'b1, 5'd1, 5'd0, 16'h1140);
    checkOutput("mid_accept", 32'(cmd_ready && cmd_valid), 1);
    for (int n = 1; n <= 151; n++) begin
      @(negedge CLK);
      cmd_valid = 1'b0;
    end
    checkOutput("mid_pre_busy", 32'(busy), 1);
    checkOutput("mid_pre_mdc", 32'(mdc), 1);
    checkOutput("mid_pre_mdio", 32'(mdio_o), 0);
    RESET = 1'b1;
    #1;
    checkOutput("mid_ready", 32'(cmd_ready), 1);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("mid_rdata", 32'(rsp_rdata), 0);
    checkOutput("mid_err", 32'(rsp_err), 0);
    checkOutput("mid_mdc", 32'(mdc), 0);
    checkOutput("mid_mdio_o", 32'(mdio_o), 1);
    checkOutput("mid_oe", 32'(mdio_oe), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    rsp_seen = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (rsp_valid || busy) rsp_seen++;
    end
    checkOutput("mid_no_rsp", 32'(rsp_seen), 0);
    applyStimulus(1'b0, 5'd1, 5'd2, 16'h0000);
    runFrame(1'b0, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h3C0F, 1'b0, "post_rst", a, r);
    stepIdle("post_rst");

    d_write = 1'b1; d_phyad = 5'd1; d_regad = 5'd0; d_wdata = 16'h1140; d_valid = 1'b1;
    checkOutput("dflt_accept", 32'(d_ready), 1);
    d_acc = cyc; d_rsp = -1; d_rises = 0; per_bad = 0; hi_bad = 0; chg_bad = 0;
    last_rise = -1;
    p_mdc = d_mdc; p_o = d_mdio_o; p_oe = d_oe;
    for (int n = 1; n <= 3300; n++) begin
      @(negedge CLK);
      d_valid = 1'b0;
      rise = !p_mdc && d_mdc;
      fall = p_mdc && !d_mdc;
      if (rise) begin
        if (last_rise >= 0 && cyc - last_rise != 50) per_bad++;
        last_rise = cyc;
        d_rises++;
      end
      if (fall && cyc - last_rise != 25) hi_bad++;
      if (n > 1 && !fall && (d_mdio_o !== p_o || d_oe !== p_oe)) chg_bad++;
      p_mdc = d_mdc; p_o = d_mdio_o; p_oe = d_oe;
      if (d_rsp_valid) begin
        d_rsp = cyc;
        break;
      end
    end
    checkOutput("dflt_rsp_latency", 32'(d_rsp - d_acc), 3201);
    checkOutput("dflt_mdc_rises", 32'(d_rises), 64);
    checkOutput("dflt_period_errs", 32'(per_bad), 0);
    checkOutput("dflt_high_errs", 32'(hi_bad), 0);
    checkOutput("dflt_mdio_change_errs", 32'(chg_bad), 0);
    checkOutput("dflt_rdata", 32'(d_rdata), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
